// File: rtl/mips32_mem_pkg.sv
// mips32_mem_pkg
// Shared types and constants for the MIPS32 single-port memory arbiter.
// Used by the arbiter, its priority picker, the pipeline wrapper and the bench.
//   req_tag_e   : owner tag carried alongside a read command
//   arb_state_e : arbiter FSM states
//   GNT_*_OH    : one-hot grant encodings, bit 0 = I, bit 1 = D, bit 2 = L
package mips32_mem_pkg;

    localparam int unsigned MEM_AW = 10;
    localparam int unsigned MEM_DW = 32;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_I    = 2'd1,
        TAG_D    = 2'd2,
        TAG_L    = 2'd3
    } req_tag_e;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam logic [2:0] GNT_NONE_OH = 3'b000;
    localparam logic [2:0] GNT_I_OH    = 3'b001;
    localparam logic [2:0] GNT_D_OH    = 3'b010;
    localparam logic [2:0] GNT_L_OH    = 3'b100;

endpackage

// File: rtl/mips32_prio_pick.sv
// mips32_prio_pick
// Combinational three-way priority selector for the memory arbiter.
//   i_req_i, d_req_i, l_req_i : pending requests
//   promote_i                 : fetch has waited long enough to beat data
//   lock_i                    : loader burst lock in force (only L may win)
//   gnt_o                     : one-hot grant {L, D, I}
module mips32_prio_pick
    import mips32_mem_pkg::*;
(
    input  logic       i_req_i,
    input  logic       d_req_i,
    input  logic       l_req_i,
    input  logic       promote_i,
    input  logic       lock_i,
    output logic [2:0] gnt_o
);

    // Loader always first; promotion only swaps I ahead of D, never breaks a lock.
    always_comb begin
        gnt_o = GNT_NONE_OH;
        if (lock_i) begin
            if (l_req_i) begin
                gnt_o = GNT_L_OH;
            end else begin
                gnt_o = GNT_NONE_OH;
            end
        end else if (l_req_i) begin
            gnt_o = GNT_L_OH;
        end else if (promote_i && i_req_i) begin
            gnt_o = GNT_I_OH;
        end else if (d_req_i) begin
            gnt_o = GNT_D_OH;
        end else if (i_req_i) begin
            gnt_o = GNT_I_OH;
        end else begin
            gnt_o = GNT_NONE_OH;
        end
    end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter
// Shares one synchronous 1024x32 word memory between fetch (I), data (D) and
// the loader/debug port (L). Grants are combinational from requests and
// registered state; the winning command is registered onto mem_* the next
// cycle, and read data is routed back two cycles after the grant using a
// two-stage owner tag pipe.
//   clk, rst_n                 : clock, synchronous active-low reset
//   i_req/i_addr               : fetch read request      -> i_gnt, i_rvalid, i_rdata
//   d_req/d_we/d_addr/d_wdata  : data load/store request -> d_gnt, d_rvalid, d_rdata
//   l_req/l_we/l_lock/l_addr/l_wdata : loader request with burst lock
//                              -> l_gnt, l_rvalid, l_rdata
//   mem_en/mem_we/mem_addr/mem_wdata : registered memory command
//   mem_rdata                  : memory read data, valid the cycle after a read command
module mips32_mem_arbiter
    import mips32_mem_pkg::*;
#(
    parameter int unsigned AW         = MEM_AW,
    parameter int unsigned DW         = MEM_DW,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic          l_lock,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_e    state_q, state_d;
    logic [3:0]    starve_q, starve_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    req_tag_e      tag_cmd_q, tag_cmd_d;
    req_tag_e      tag_rsp_q;

    logic          promote_s;
    logic          lock_s;
    logic [2:0]    pick_s;
    logic [2:0]    gnt_s;

    assign promote_s = (starve_q == STARVE_LIM);
    // The cycle that drops l_lock already arbitrates with normal priority.
    assign lock_s    = (state_q == LOCK) && l_lock;

    mips32_prio_pick u_pick (
        .i_req_i   (i_req),
        .d_req_i   (d_req),
        .l_req_i   (l_req),
        .promote_i (promote_s),
        .lock_i    (lock_s),
        .gnt_o     (pick_s)
    );

    assign gnt_s = rst_n ? pick_s : GNT_NONE_OH;
    assign i_gnt = gnt_s[0];
    assign d_gnt = gnt_s[1];
    assign l_gnt = gnt_s[2];

    // Next-state: FSM, starvation counter and the command/tag to register.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tag_cmd_d   = TAG_NONE;

        case (state_q)
            ARB: begin
                if (l_gnt && l_lock) begin
                    state_d = LOCK;
                end else begin
                    state_d = ARB;
                end
            end
            LOCK: begin
                if (!l_lock) begin
                    state_d = ARB;
                end else begin
                    state_d = LOCK;
                end
            end
            default: state_d = ARB;
        endcase

        if (i_req && !i_gnt) begin
            if (starve_q < STARVE_LIM) begin
                starve_d = starve_q + 4'd1;
            end else begin
                starve_d = starve_q;
            end
        end else begin
            starve_d = 4'd0;
        end

        case (gnt_s)
            GNT_I_OH: begin
                mem_en_d   = 1'b1;
                mem_addr_d = i_addr;
                tag_cmd_d  = TAG_I;
            end
            GNT_D_OH: begin
                mem_en_d    = 1'b1;
                mem_we_d    = d_we;
                mem_addr_d  = d_addr;
                mem_wdata_d = d_wdata;
                tag_cmd_d   = d_we ? TAG_NONE : TAG_D;
            end
            GNT_L_OH: begin
                mem_en_d    = 1'b1;
                mem_we_d    = l_we;
                mem_addr_d  = l_addr;
                mem_wdata_d = l_wdata;
                tag_cmd_d   = l_we ? TAG_NONE : TAG_L;
            end
            default: begin
                mem_en_d  = 1'b0;
                tag_cmd_d = TAG_NONE;
            end
        endcase
    end

    // State, command register and tag pipe; reset drops any in-flight read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB;
            starve_q    <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= {DW{1'b0}};
            tag_cmd_q   <= TAG_NONE;
            tag_rsp_q   <= TAG_NONE;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tag_cmd_q   <= tag_cmd_d;
            tag_rsp_q   <= tag_cmd_q;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // The response stage tag selects which requester sees mem_rdata.
    assign i_rvalid = (tag_rsp_q == TAG_I);
    assign d_rvalid = (tag_rsp_q == TAG_D);
    assign l_rvalid = (tag_rsp_q == TAG_L);
    assign i_rdata  = i_rvalid ? mem_rdata : {DW{1'b0}};
    assign d_rdata  = d_rvalid ? mem_rdata : {DW{1'b0}};
    assign l_rdata  = l_rvalid ? mem_rdata : {DW{1'b0}};

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Self-checking bench for mips32_mem_arbiter: directed scenarios plus a
// randomized run against a behavioural model of the arbitration rules.
module tb_mips32_mem_arbiter;
    import mips32_mem_pkg::*;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, i_gnt, i_rvalid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          l_req, l_we, l_lock, l_gnt, l_rvalid;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata, l_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] tb_mem [0:1023];
    logic [DW-1:0] shadow [0:15];

    typedef struct {
        req_tag_e    who;
        logic [31:0] data;
        int          due;
    } rsp_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mips32_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory, read data valid the cycle after the command.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0; l_addr = '0; l_wdata = '0;
    endtask

    task automatic flush(input int n);
        idle_inputs();
        repeat (n) tick();
    endtask

    // Writes one word through the loader port (top priority, no lock).
    task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] v);
        l_req = 1'b1; l_we = 1'b1; l_lock = 1'b0; l_addr = a; l_wdata = v;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_req = 1'b1; d_req = 1'b1; l_req = 1'b1;
        tick(); tick();
        checks++;
        if ({l_gnt, d_gnt, i_gnt} !== 3'b000) begin
            errors++; $display("FAIL reset_gnt got=%b exp=000", {l_gnt, d_gnt, i_gnt});
        end
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b0, 1'b0, 10'd0, 32'd0}) begin
            errors++; $display("FAIL reset_mem got en=%b we=%b a=%0d wd=%h exp all 0", mem_en, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if ({i_rvalid, d_rvalid, l_rvalid, i_rdata, d_rdata, l_rdata} !== 99'd0) begin
            errors++; $display("FAIL reset_rsp got rv=%b%b%b exp rv=000 rdata=0", i_rvalid, d_rvalid, l_rvalid);
        end
        idle_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        load_word(10'd5, 32'h0000_1234);
        i_req = 1'b1; i_addr = 10'd5;
        #1;
        checks++;
        if ({l_gnt, d_gnt, i_gnt} !== 3'b001) begin
            errors++; $display("FAIL single_gnt got=%b exp=001", {l_gnt, d_gnt, i_gnt});
        end
        tick();
        i_req = 1'b0;
        #1;
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd5}) begin
            errors++; $display("FAIL single_cmd got en=%b we=%b a=%0d exp en=1 we=0 a=5", mem_en, mem_we, mem_addr);
        end
        tick();
        checks++;
        if ({i_rvalid, d_rvalid, l_rvalid, i_rdata, d_rdata, l_rdata} !== {3'b100, 32'h1234, 64'd0}) begin
            errors++; $display("FAIL single_rsp got rv=%b%b%b i_rdata=%h exp rv=100 i_rdata=1234", i_rvalid, d_rvalid, l_rvalid, i_rdata);
        end
        tick();
        checks++;
        if ({i_rvalid, d_rvalid, l_rvalid} !== 3'b000) begin
            errors++; $display("FAIL single_rv_end got=%b exp=000", {i_rvalid, d_rvalid, l_rvalid});
        end
    endtask

    task automatic test_contention();
        logic [2:0]  exp_g  [0:4];
        logic [2:0]  exp_rv [0:4];
        logic [2:0]  g;
        logic [95:0] exp_rd;
        exp_g  = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b000};
        exp_rv = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b001};
        load_word(10'd10, 32'hAAAA_0010);
        load_word(10'd11, 32'hBBBB_0011);
        load_word(10'd12, 32'hCCCC_0012);
        i_req = 1'b1; i_addr = 10'd10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd11;
        l_req = 1'b1; l_we = 1'b0; l_addr = 10'd12;
        for (int w = 0; w < 5; w++) begin
            #1;
            g = {l_gnt, d_gnt, i_gnt};
            checks++;
            if (g !== exp_g[w]) begin
                errors++; $display("FAIL contention_gnt w=%0d got=%b exp=%b", w, g, exp_g[w]);
            end
            exp_rd = {exp_rv[w][2] ? 32'hCCCC_0012 : 32'd0,
                      exp_rv[w][1] ? 32'hBBBB_0011 : 32'd0,
                      exp_rv[w][0] ? 32'hAAAA_0010 : 32'd0};
            checks++;
            if ({l_rvalid, d_rvalid, i_rvalid, l_rdata, d_rdata, i_rdata} !== {exp_rv[w], exp_rd}) begin
                errors++; $display("FAIL contention_rsp w=%0d got rv=%b%b%b exp rv=%b", w, l_rvalid, d_rvalid, i_rvalid, exp_rv[w]);
            end
            tick();
            if (g[2]) l_req = 1'b0;
            if (g[1]) d_req = 1'b0;
            if (g[0]) i_req = 1'b0;
        end
        flush(2);
    endtask

    task automatic test_starvation();
        logic [2:0] exp;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd0;
        i_req = 1'b1; i_addr = 10'd1;
        for (int w = 0; w < 10; w++) begin
            #1;
            exp = ((w % 5) == 4) ? 3'b001 : 3'b010;
            checks++;
            if ({l_gnt, d_gnt, i_gnt} !== exp) begin
                errors++; $display("FAIL starve_gnt w=%0d got=%b exp=%b", w, {l_gnt, d_gnt, i_gnt}, exp);
            end
            tick();
        end
        flush(3);
    endtask

    task automatic test_loader_burst();
        logic [2:0]  exp;
        logic [31:0] k;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd3;
        for (int w = 0; w < 10; w++) begin
            if (w == 4) begin
                l_req = 1'b0; l_lock = 1'b1; exp = 3'b000;
            end else if (w == 9) begin
                l_req = 1'b0; l_lock = 1'b0; exp = 3'b010;
            end else begin
                k = (w < 4) ? 32'(w) : 32'(w - 1);
                l_req = 1'b1; l_we = 1'b1; l_addr = AW'(k);
                l_wdata = 32'hC0DE_0000 + k; l_lock = (w != 8);
                exp = 3'b100;
            end
            #1;
            checks++;
            if ({l_gnt, d_gnt, i_gnt} !== exp) begin
                errors++; $display("FAIL burst_gnt w=%0d got=%b exp=%b", w, {l_gnt, d_gnt, i_gnt}, exp);
            end
            tick();
        end
        idle_inputs();
        tick();
        checks++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'hC0DE_0003}) begin
            errors++; $display("FAIL burst_readback got rv=%b data=%h exp rv=1 data=c0de0003", d_rvalid, d_rdata);
        end
        flush(2);
    endtask

    task automatic test_back_to_back();
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'd9; d_wdata = 32'h0000_AAAA;
        #1;
        checks++;
        if ({l_gnt, d_gnt, i_gnt} !== 3'b010) begin
            errors++; $display("FAIL raw_wr_gnt got=%b exp=010", {l_gnt, d_gnt, i_gnt});
        end
        tick();
        d_we = 1'b0;
        #1;
        checks++;
        if ({d_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 1'b1, 10'd9, 32'h0000_AAAA}) begin
            errors++; $display("FAIL raw_wr_cmd got gnt=%b en=%b we=%b a=%0d wd=%h exp 1 1 1 9 aaaa", d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick();
        d_req = 1'b0;
        #1;
        checks++;
        if ({mem_en, mem_we, mem_addr, d_rvalid} !== {1'b1, 1'b0, 10'd9, 1'b0}) begin
            errors++; $display("FAIL raw_rd_cmd got en=%b we=%b a=%0d rv=%b exp 1 0 9 0", mem_en, mem_we, mem_addr, d_rvalid);
        end
        tick();
        checks++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'h0000_AAAA}) begin
            errors++; $display("FAIL raw_rsp got rv=%b data=%h exp rv=1 data=aaaa", d_rvalid, d_rdata);
        end
        flush(2);
    endtask

    task automatic test_reset_midop();
        logic [2:0] exp;
        i_req = 1'b1; i_addr = 10'd5;
        #1;
        checks++;
        if (i_gnt !== 1'b1) begin
            errors++; $display("FAIL midrst_gnt got=%b exp=1", i_gnt);
        end
        tick();
        rst_n = 1'b0; d_req = 1'b1;
        #1;
        checks++;
        if ({l_gnt, d_gnt, i_gnt} !== 3'b000) begin
            errors++; $display("FAIL midrst_gnt_low got=%b exp=000", {l_gnt, d_gnt, i_gnt});
        end
        tick();
        rst_n = 1'b1; idle_inputs();
        for (int w = 0; w < 2; w++) begin
            #1;
            checks++;
            if ({mem_en, i_rvalid, d_rvalid, l_rvalid} !== 4'b0000) begin
                errors++; $display("FAIL midrst_drop w=%0d got en=%b rv=%b%b%b exp all 0", w, mem_en, i_rvalid, d_rvalid, l_rvalid);
            end
            tick();
        end
        // Enter a lock and build up fetch starvation, then reset over it.
        l_req = 1'b1; l_we = 1'b1; l_lock = 1'b1; l_addr = 10'd20; l_wdata = 32'h5555_0020;
        i_req = 1'b1; i_addr = 10'd5;
        #1;
        checks++;
        if ({l_gnt, d_gnt, i_gnt} !== 3'b100) begin
            errors++; $display("FAIL midrst_lock_gnt got=%b exp=100", {l_gnt, d_gnt, i_gnt});
        end
        tick();
        l_req = 1'b0;
        for (int w = 0; w < 2; w++) begin
            #1;
            checks++;
            if ({l_gnt, d_gnt, i_gnt} !== 3'b000) begin
                errors++; $display("FAIL lock_blocks w=%0d got=%b exp=000", w, {l_gnt, d_gnt, i_gnt});
            end
            tick();
        end
        rst_n = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd1;
        tick();
        rst_n = 1'b1;
        for (int w = 0; w < 5; w++) begin
            #1;
            exp = (w == 4) ? 3'b001 : 3'b010;
            checks++;
            if ({l_gnt, d_gnt, i_gnt} !== exp) begin
                errors++; $display("FAIL postrst_arb w=%0d got=%b exp=%b", w, {l_gnt, d_gnt, i_gnt}, exp);
            end
            tick();
        end
        flush(3);
    endtask

    task automatic test_random();
        rsp_t        q[$];
        rsp_t        r;
        bit          burst;
        bit          eff;
        int          m_starve;
        logic [2:0]  exp;
        logic [2:0]  exp_rv;
        logic [95:0] exp_rd;
        bit          c_en;
        logic        c_we;
        logic [9:0]  c_addr;
        logic [31:0] c_wd;
        logic [31:0] v;
        for (int a = 0; a < 16; a++) begin
            v = $urandom;
            shadow[a] = v;
            load_word(AW'(a), v);
        end
        flush(2);
        burst = 1'b0; m_starve = 0; c_en = 1'b0;
        c_we = 1'b0; c_addr = '0; c_wd = '0;
        for (int n = 0; n < 400; n++) begin
            if (!i_req && $urandom_range(0, 1) == 1) begin
                i_req = 1'b1; i_addr = AW'($urandom_range(0, 15));
            end
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = AW'($urandom_range(0, 15)); d_wdata = $urandom;
            end
            if (!l_req) begin
                l_lock = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 3) == 0) begin
                    l_req = 1'b1; l_we = 1'($urandom_range(0, 1));
                    l_addr = AW'($urandom_range(0, 15)); l_wdata = $urandom;
                end
            end
            #1;
            eff = burst && l_lock;
            if (eff)                            exp = l_req ? 3'b100 : 3'b000;
            else if (l_req)                     exp = 3'b100;
            else if (m_starve == SMAX && i_req) exp = 3'b001;
            else if (d_req)                     exp = 3'b010;
            else if (i_req)                     exp = 3'b001;
            else                                exp = 3'b000;
            checks++;
            if ({l_gnt, d_gnt, i_gnt} !== exp) begin
                errors++; $display("FAIL rand_gnt n=%0d got=%b exp=%b", n, {l_gnt, d_gnt, i_gnt}, exp);
            end
            exp_rv = 3'b000; exp_rd = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                r = q.pop_front();
                if (r.who == TAG_L) begin exp_rv = 3'b100; exp_rd[95:64] = r.data; end
                if (r.who == TAG_D) begin exp_rv = 3'b010; exp_rd[63:32] = r.data; end
                if (r.who == TAG_I) begin exp_rv = 3'b001; exp_rd[31:0]  = r.data; end
            end
            checks++;
            if ({l_rvalid, d_rvalid, i_rvalid, l_rdata, d_rdata, i_rdata} !== {exp_rv, exp_rd}) begin
                errors++; $display("FAIL rand_rsp n=%0d got rv=%b%b%b l=%h d=%h i=%h exp rv=%b data=%h", n, l_rvalid, d_rvalid, i_rvalid, l_rdata, d_rdata, i_rdata, exp_rv, exp_rd);
            end
            checks++;
            if (!c_en) begin
                if (mem_en !== 1'b0) begin
                    errors++; $display("FAIL rand_cmd_idle n=%0d got en=%b exp en=0", n, mem_en);
                end
            end else if ({mem_en, mem_we, mem_addr} !== {1'b1, c_we, c_addr} || (c_we && mem_wdata !== c_wd)) begin
                errors++; $display("FAIL rand_cmd n=%0d got en=%b we=%b a=%0d wd=%h exp en=1 we=%b a=%0d wd=%h", n, mem_en, mem_we, mem_addr, mem_wdata, c_we, c_addr, c_wd);
            end
            c_en = (exp != 3'b000);
            if (exp == 3'b100) begin c_we = l_we; c_addr = l_addr; c_wd = l_wdata; end
            if (exp == 3'b010) begin c_we = d_we; c_addr = d_addr; c_wd = d_wdata; end
            if (exp == 3'b001) begin c_we = 1'b0; c_addr = i_addr; c_wd = '0; end
            if (c_en) begin
                if (c_we) begin
                    shadow[c_addr[3:0]] = c_wd;
                end else begin
                    r.who  = (exp == 3'b100) ? TAG_L : (exp == 3'b010) ? TAG_D : TAG_I;
                    r.data = shadow[c_addr[3:0]];
                    r.due  = cyc + 2;
                    q.push_back(r);
                end
            end
            burst = eff ? 1'b1 : (exp[2] && l_lock);
            if (i_req && !exp[0]) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
            else                  m_starve = 0;
            tick();
            if (exp[2]) l_req = 1'b0;
            if (exp[1]) d_req = 1'b0;
            if (exp[0]) i_req = 1'b0;
        end
        flush(3);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_starvation();
        test_loader_burst();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
